io_arbiter: RTL and testbench

Sequencer and two-requester arbiter for the 8-bit IO bus. Accepts read/write requests from requester 0 (CPU) and requester 1 (debug/loader port) and grants one at a time. Drives the peripheral-side strobes (select, address, active-low output enable, active-low write enable) with programmable setup and strobe phases. Returns read data and a one-cycle acknowledge to the granted requester. Sits between the requesters and the IO peripherals, such as the switch/7-segment unit at IO address 0x00.

---
 rtl/io_arbiter.sv | 123 ++++++++++++
 tb/tb_io_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/io_arbiter.sv
// io_arbiter: two-requester IO bus sequencer with programmable setup/strobe phases
// Ports: i_clk/i_reset (sync, active-high); i_reqN/i_weN/i_addrN/i_wdataN requests,
// o_ackN one-cycle completion; o_rdata shared read data; o_ioSelect/o_ioAddress/
// o_ioNOE/o_ioNWE peripheral strobes; o_bus/o_busDrive write data; i_bus read data.
// Build option IO_ARB_RR_EN: round-robin on simultaneous requests, else requester 0 wins.
module io_arbiter #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_we0,
  input  logic       i_we1,
  input  logic [7:0] i_addr0,
  input  logic [7:0] i_addr1,
  input  logic [7:0] i_wdata0,
  input  logic [7:0] i_wdata1,
  output logic       o_ack0,
  output logic       o_ack1,
  output logic [7:0] o_rdata,
  output logic       o_ioSelect,
  output logic [7:0] o_ioAddress,
  output logic       o_ioNOE,
  output logic       o_ioNWE,
  output logic [7:0] o_bus,
  output logic       o_busDrive,
  input  logic [7:0] i_bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt_q, gnt_d, we_q, we_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic       sel_q, noe_q, nwe_q, drive_q, ack0_q, ack1_q;
  logic       start, win;
  assign start = (state_q == IDLE) & (i_req0 | i_req1);
`ifdef IO_ARB_RR_EN
  // last_q holds the last granted requester; reset to 1 so requester 0 wins first
  logic last_q;
  assign win = (i_req0 & i_req1) ? ~last_q : ~i_req0;
  always_ff @(posedge i_clk) begin
    if (i_reset) last_q <= 1'b1;
    else if (start) last_q <= win;
  end
`else
  assign win = ~i_req0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        cnt_d   = 4'(SETUP_CYCLES - 1);
        gnt_d   = win;
        we_d    = win ? i_we1 : i_we0;
        addr_d  = win ? i_addr1 : i_addr0;
        wdata_d = win ? i_wdata1 : i_wdata0;
      end
      SETUP: begin
        state_d = cnt_q == '0 ? STROBE : SETUP;
        cnt_d   = cnt_q == '0 ? 4'(STROBE_CYCLES - 1) : cnt_q - 4'd1;
      end
      STROBE: begin
        state_d = cnt_q == '0 ? HOLD : STROBE;
        cnt_d   = cnt_q - 4'd1;
        rdata_d = (cnt_q == '0 && !we_q) ? i_bus : rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // Strobe outputs are registered from the next state so they line up with it
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q   <= 1'b0;
      noe_q   <= 1'b1;
      nwe_q   <= 1'b1;
      drive_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      sel_q   <= state_d != IDLE;
      noe_q   <= !(state_d == STROBE && !we_d);
      nwe_q   <= !(state_d == STROBE && we_d);
      drive_q <= state_d != IDLE && we_d;
      ack0_q  <= state_d == HOLD && !gnt_d;
      ack1_q  <= state_d == HOLD && gnt_d;
    end
  end
  assign o_ack0      = ack0_q;
  assign o_ack1      = ack1_q;
  assign o_rdata     = rdata_q;
  assign o_ioSelect  = sel_q;
  assign o_ioAddress = addr_q;
  assign o_ioNOE     = noe_q;
  assign o_ioNWE     = nwe_q;
  assign o_bus       = wdata_q;
  assign o_busDrive  = drive_q;
endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: directed vectors, corner sequences and random traffic against a phase model
module tb_io_arbiter;
  localparam int S = 1;
  localparam int T = 2;
`ifdef IO_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1, bus_in;
  logic ack0, ack1, sel, noe, nwe, drv;
  logic [7:0] rdata, addr_o, bus_o;
  logic req0b;
  logic [7:0] wdata0b;
  logic b_ack0, b_ack1, b_sel, b_noe, b_nwe, b_drv;
  logic [7:0] b_rdata, b_addr, b_bus;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int last_cyc, lo_n, lo_first, ack_at, sel_n, a_n;
  bit m_busy, m_gnt, m_we, m_last;
  int m_k;
  logic [7:0] m_addr, m_wdata, m_rdata;
  typedef struct packed {
    logic rst, r0, w0;
    logic [7:0] a0, d0;
    logic r1, w1;
    logic [7:0] a1, d1, bi;
    logic [5:0] ctl;
    logic [7:0] rd;
    logic bchk;
    logic [7:0] eb;
  } vec_t;
  vec_t vec [12];
  always #5 clk = ~clk;
  io_arbiter dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata(rdata),
    .o_ioSelect(sel), .o_ioAddress(addr_o), .o_ioNOE(noe), .o_ioNWE(nwe),
    .o_bus(bus_o), .o_busDrive(drv), .i_bus(bus_in)
  );
  io_arbiter #(.SETUP_CYCLES(3), .STROBE_CYCLES(4)) dut2 (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req0b), .i_req1(1'b0), .i_we0(1'b1), .i_we1(1'b0),
    .i_addr0(8'h00), .i_addr1(8'h00), .i_wdata0(wdata0b), .i_wdata1(8'h00),
    .o_ack0(b_ack0), .o_ack1(b_ack1), .o_rdata(b_rdata),
    .o_ioSelect(b_sel), .o_ioAddress(b_addr), .o_ioNOE(b_noe), .o_ioNWE(b_nwe),
    .o_bus(b_bus), .o_busDrive(b_drv), .i_bus(8'h00)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc_n);
    end
  endtask
  // Transaction-level model: a phase index k counts cycles since the grant
  task automatic model_step();
    if (rst) begin
      m_busy = 0;
      m_k = 0;
      m_last = 1;
      m_rdata = 8'h00;
    end else if (!m_busy) begin
      if (req0 || req1) begin
        m_gnt = (req0 && req1) ? (RR ? !m_last : 1'b0) : req1;
        m_last = m_gnt;
        m_we = m_gnt ? we1 : we0;
        m_addr = m_gnt ? addr1 : addr0;
        m_wdata = m_gnt ? wdata1 : wdata0;
        m_busy = 1;
        m_k = 1;
      end
    end else if (m_k == S + T + 1) begin
      m_busy = 0;
      m_k = 0;
    end else begin
      if (m_k == S + T && !m_we) m_rdata = bus_in;
      m_k++;
    end
  endtask
  task automatic model_check();
    bit strobe;
    bit hold;
    strobe = m_busy && m_k >= S + 1 && m_k <= S + T;
    hold = m_busy && m_k == S + T + 1;
    chk("model_ctl", {sel, noe, nwe, drv, ack0, ack1, rdata},
        {m_busy, !(strobe && !m_we), !(strobe && m_we), m_busy && m_we, hold && !m_gnt, hold && m_gnt, m_rdata});
    if (m_busy) chk("model_addr", addr_o, m_addr);
    if (m_busy && m_we) chk("model_bus", bus_o, m_wdata);
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    cyc_n++;
    model_check();
  endtask
  task automatic wait_ack(input string nm);
    for (int i = 0; i < 20 && !(ack0 || ack1); i++) cyc();
    chk(nm, ack0 | ack1, 1'b1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    {req0, req1, we0, we1} = '0;
    {addr0, addr1, wdata0, wdata1, bus_in} = '0;
    req0b = 1'b0;
    wdata0b = 8'h00;
    vec[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 6'b011000, 8'h00, 1'b0, 8'h00};
    vec[1]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 6'b111100, 8'h00, 1'b1, 8'hA5};
    vec[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 6'b110100, 8'h00, 1'b1, 8'hA5};
    vec[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 6'b110100, 8'h00, 1'b1, 8'hA5};
    vec[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 6'b111110, 8'h00, 1'b1, 8'hA5};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 6'b011000, 8'h00, 1'b0, 8'h00};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h3C, 6'b111000, 8'h00, 1'b0, 8'h00};
    vec[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h3C, 6'b101000, 8'h00, 1'b0, 8'h00};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h3C, 6'b101000, 8'h00, 1'b0, 8'h00};
    vec[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h3C, 6'b111001, 8'h3C, 1'b0, 8'h00};
    vec[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 6'b011000, 8'h3C, 1'b0, 8'h00};
    vec[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 6'b011000, 8'h3C, 1'b0, 8'h00};
    for (int i = 0; i < 12; i++) begin
      {rst, req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, bus_in} =
        {vec[i].rst, vec[i].r0, vec[i].w0, vec[i].a0, vec[i].d0, vec[i].r1, vec[i].w1, vec[i].a1, vec[i].d1, vec[i].bi};
      cyc();
      chk($sformatf("vec%0d", i), {sel, noe, nwe, drv, ack0, ack1, rdata}, {vec[i].ctl, vec[i].rd});
      if (vec[i].bchk) chk($sformatf("vec%0d_bus", i), {addr_o, bus_o}, {8'h00, vec[i].eb});
    end
    // reset in the middle of a requester-0 read strobe, then both requesters contend
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10; bus_in = 8'h77;
    cyc();
    cyc();
    chk("rst_pre_strobe", noe, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_outputs", {sel, noe, nwe, drv, ack0, ack1, rdata}, {6'b011000, 8'h00});
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    wait_ack("first_ack_timeout");
    chk("first_after_reset", {ack1, ack0}, 2'b01);
    last_cyc = cyc_n;
    for (int n = 0; n < 3; n++) begin
      cyc();
      wait_ack("alt_ack_timeout");
      chk("alt_who", {ack1, ack0}, RR ? ((n % 2 == 0) ? 2'b10 : 2'b01) : 2'b01);
      chk("alt_gap", cyc_n - last_cyc, S + T + 2);
      last_cyc = cyc_n;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    // requester 0 drops its request during SETUP
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h22; wdata0 = 8'h5A;
    cyc();
    req0 = 1'b0;
    sel_n = int'(sel);
    a_n = 0;
    ack_at = 0;
    for (int c = 2; c <= 10; c++) begin
      cyc();
      sel_n += int'(sel);
      if (ack0) begin a_n++; ack_at = c; end
    end
    chk("drop_ack_count", a_n, 1);
    chk("drop_ack_cycle", ack_at, 4);
    chk("drop_sel_cycles", sel_n, 4);
    // long setup/strobe instance: write timing
    req0b = 1'b1; wdata0b = 8'h99;
    lo_n = 0; lo_first = 0; ack_at = 0; sel_n = 0;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (!b_nwe) begin
        lo_n++;
        if (lo_first == 0) lo_first = c;
      end
      if (b_sel) sel_n++;
      if (c == 5) chk("long_bus", {b_drv, b_bus}, {1'b1, 8'h99});
      if (b_ack1) chk("long_ack1", b_ack1, 1'b0);
      if (b_ack0) begin ack_at = c; req0b = 1'b0; end
    end
    chk("long_nwe_len", lo_n, 4);
    chk("long_nwe_first", lo_first, 4);
    chk("long_ack_cycle", ack_at, 8);
    chk("long_sel_len", sel_n, 8);
    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom % 97) == 0;
      bus_in = 8'($urandom);
      if (!req0) begin
        if ($urandom % 3 == 0) begin
          req0 = 1'b1; we0 = 1'($urandom); addr0 = 8'($urandom); wdata0 = 8'($urandom);
        end
      end else if (ack0) req0 = ($urandom % 4) == 0;
      else if ($urandom % 50 == 0) req0 = 1'b0;
      if (!req1) begin
        if ($urandom % 3 == 0) begin
          req1 = 1'b1; we1 = 1'($urandom); addr1 = 8'($urandom); wdata1 = 8'($urandom);
        end
      end else if (ack1) req1 = ($urandom % 4) == 0;
      else if ($urandom % 50 == 0) req1 = 1'b0;
      cyc();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
